// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART transmitter state encoding, default parameters and width helper.
package uart_pkg;

  localparam int DEF_NB_DATA   = 8;
  localparam int DEF_SB_TICK   = 16;
  localparam int DEF_BAUD_DIV  = 163;
  localparam int TICKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int width_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_module_if.sv
// rtl/uart_tx_module_if.sv - TX FIFO pop handshake between the FIFO (master) and the transmitter (slave).
interface uart_tx_module_if
  import uart_pkg::*;
#(
  parameter int NB_DATA = DEF_NB_DATA
);

  logic               i_fifo_empty;
  logic [NB_DATA-1:0] i_fifo_data;
  logic               o_fifo_read;

  modport master (
    output i_fifo_empty,
    output i_fifo_data,
    input  o_fifo_read
  );

  modport slave (
    input  i_fifo_empty,
    input  i_fifo_data,
    output o_fifo_read
  );

endinterface

// File: rtl/baud_rate_gen.sv
// rtl/baud_rate_gen.sv - Oversample tick generator; i_clear re-phases the tick to a frame start.
module baud_rate_gen
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = DEF_BAUD_DIV
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int               CNT_W   = width_for(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign o_tick = (cnt_q == CNT_MAX);

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      cnt_q <= '0;
    end else if (o_tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_module.sv
// rtl/uart_tx_module.sv - UART transmitter fed from a TX FIFO; UART_TX_PARITY_EN adds an even parity bit.
module uart_tx_module
  import uart_pkg::*;
#(
  parameter int NB_DATA  = DEF_NB_DATA,
  parameter int SB_TICK  = DEF_SB_TICK,
  parameter int BAUD_DIV = DEF_BAUD_DIV
) (
  input  logic              i_clk,
  input  logic              i_reset,
  uart_tx_module_if.slave   fifo,
  output logic              o_tx,
  output logic              o_busy
);

  localparam int TICK_SPAN = (SB_TICK > TICKS_PER_BIT) ? SB_TICK : TICKS_PER_BIT;
  localparam int TICK_W    = width_for(TICK_SPAN);
  localparam int BIT_W     = width_for(NB_DATA);

  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(TICKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(SB_TICK - 1);
  localparam logic [BIT_W-1:0]  IDX_LAST  = BIT_W'(NB_DATA - 1);

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]    bit_idx_q, bit_idx_d;
  logic [NB_DATA-1:0]  shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                fifo_read;
  logic                tick;
`ifdef UART_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  baud_rate_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_rate_gen (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (fifo_read),
    .o_tick  (tick)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo.i_fifo_empty) begin
          state_d    = ST_START;
          shift_d    = fifo.i_fifo_data;
          tick_cnt_d = '0;
          bit_idx_d  = '0;
`ifdef UART_TX_PARITY_EN
          parity_d   = ^fifo.i_fifo_data;
`endif
        end
      end
      ST_START: begin
        if (tick) begin
          if (tick_cnt_q == BIT_LAST) begin
            state_d    = ST_DATA;
            tick_cnt_d = '0;
            bit_idx_d  = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (tick_cnt_q == BIT_LAST) begin
            tick_cnt_d = '0;
            shift_d    = shift_q >> 1;
            // The index returns to zero only by leaving DATA.
            if (bit_idx_q == IDX_LAST) begin
              bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
              state_d   = ST_PARITY;
`else
              state_d   = ST_STOP;
`endif
            end else begin
              bit_idx_d = bit_idx_q + BIT_W'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          if (tick_cnt_q == BIT_LAST) begin
            state_d    = ST_STOP;
            tick_cnt_d = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (tick_cnt_q == STOP_LAST) begin
            state_d    = ST_IDLE;
            tick_cnt_d = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        tick_cnt_d = '0;
        bit_idx_d  = '0;
      end
    endcase
  end

  // The line level is derived from the next state so the registered o_tx lines up with state_q.
  always_comb begin
    fifo_read = (state_q == ST_IDLE) && !fifo.i_fifo_empty && !i_reset;
    o_busy    = (state_q != ST_IDLE);
    tx_d      = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_q;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign fifo.o_fifo_read = fifo_read;
  assign o_tx             = tx_q;

endmodule

// File: tb/tb_uart_tx_module.sv
// tb/tb_uart_tx_module.sv - Scoreboard bench for uart_tx_module with a FIFO model and serial-line monitor.
module tb_uart_tx_module;

  localparam int BIT_CYC = 64;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int GAP = NBITS * BIT_CYC + 1;

  typedef struct {
    logic [11:0] frame;
    bit          gap_chk;
    bit          abort;
  } exp_t;

  logic clk = 1'b0;
  logic i_reset = 1'b1;
  logic o_tx;
  logic o_busy;

  int n_cmp = 0;
  int n_bad = 0;
  int n_reads = 0;
  int cyc = 0;

  logic [7:0] fifo_q[$];
  exp_t       sb[$];

  uart_tx_module_if #(.NB_DATA(8)) fifo_if ();

  uart_tx_module #(
    .NB_DATA  (8),
    .SB_TICK  (16),
    .BAUD_DIV (4)
  ) dut (
    .i_clk   (clk),
    .i_reset (i_reset),
    .fifo    (fifo_if),
    .o_tx    (o_tx),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    fifo_if.i_fifo_empty = (fifo_q.size() == 0);
    fifo_if.i_fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  // p is the hand-computed even parity of d.
  task automatic send(input logic [7:0] d, input logic p, input bit gap_chk, input bit abort);
    exp_t e;
`ifdef UART_TX_PARITY_EN
    e.frame = {1'b0, 1'b1, p, d, 1'b0};
`else
    e.frame = {2'b00, 1'b1, d, 1'b0};
    if (p) e.frame[11] = 1'b0;
`endif
    e.gap_chk = gap_chk;
    e.abort   = abort;
    sb.push_back(e);
    fifo_q.push_back(d);
    refresh();
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !o_busy && fifo_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    check({name, "_drain"}, 32'(done), 32'd1);
  endtask

  // FIFO model: pop after the edge that consumed the head word.
  initial begin : fifo_model
    forever begin
      @(negedge clk);
      if (fifo_if.o_fifo_read === 1'b1) begin
        @(posedge clk);
        #1;
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        refresh();
      end
    end
  end

  initial begin : monitor
    int   last_rd;
    bit   prev_done;
    exp_t e;
    last_rd   = -100000;
    prev_done = 0;
    forever begin
      @(negedge clk);
      if (prev_done) begin
        check("idle_after_stop_busy", 32'(o_busy), 32'd0);
        prev_done = 0;
      end
      if (fifo_if.o_fifo_read === 1'b1) begin
        n_reads++;
        check("read_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          int   nchk;
          logic rd_seen;
          e = sb.pop_front();
          if (e.gap_chk) check("read_gap", 32'(cyc - last_rd), 32'(GAP));
          last_rd = cyc;
          nchk    = e.abort ? 4 : NBITS;
          rd_seen = 1'b0;
          for (int k = 0; k < nchk; k++) begin
            logic tx_seen;
            logic busy_seen;
            tx_seen   = e.frame[k];
            busy_seen = 1'b1;
            for (int c = 0; c < BIT_CYC; c++) begin
              @(negedge clk);
              if (o_tx !== e.frame[k]) tx_seen = o_tx;
              if (o_busy !== 1'b1) busy_seen = o_busy;
              if (fifo_if.o_fifo_read !== 1'b0) rd_seen = 1'b1;
            end
            check($sformatf("frame_bit%0d", k), 32'(tx_seen), 32'(e.frame[k]));
            check($sformatf("frame_busy%0d", k), 32'(busy_seen), 32'd1);
          end
          check("frame_no_extra_read", 32'(rd_seen), 32'd0);
          prev_done = !e.abort;
        end
      end
    end
  end

  initial begin : watchdog
    repeat (40000) @(posedge clk);
    $display("FAIL watchdog: got cycle %0d expected finish before", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit tx_hi;
    bit seen;
    int rd0;
    refresh();
    i_reset = 1'b1;
    @(negedge clk);
    check("reset_tx", 32'(o_tx), 32'd1);
    check("reset_read", 32'(fifo_if.o_fifo_read), 32'd0);
    check("reset_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 i_reset = 1'b0;

    @(posedge clk);
    #1 send(8'hA5, 1'b0, 0, 0);
    wait_idle("a5");

    rd0   = n_reads;
    tx_hi = 1;
    repeat (2000) begin
      @(negedge clk);
      if (o_tx !== 1'b1) tx_hi = 0;
    end
    check("empty_no_read", 32'(n_reads), 32'(rd0));
    check("empty_tx_high", 32'(tx_hi), 32'd1);

    @(posedge clk);
    #1;
    send(8'h00, 1'b0, 0, 0);
    send(8'hFF, 1'b0, 1, 0);
    wait_idle("b2b_00_ff");

    @(posedge clk);
    #1;
    send(8'h07, 1'b1, 0, 0);
    send(8'h81, 1'b0, 1, 0);
    send(8'h80, 1'b1, 1, 0);
    wait_idle("b2b_07_81_80");

    @(posedge clk);
    #1;
    send(8'h5A, 1'b0, 0, 1);
    send(8'hC3, 1'b0, 0, 0);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fifo_if.o_fifo_read === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check("abort_read_seen", 32'(seen), 32'd1);
    repeat (266) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    check("midreset_tx", 32'(o_tx), 32'd1);
    check("midreset_busy", 32'(o_busy), 32'd0);
    check("midreset_read", 32'(fifo_if.o_fifo_read), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("midreset_hold_read", 32'(fifo_if.o_fifo_read), 32'd0);
    @(posedge clk);
    #1 i_reset = 1'b0;
    wait_idle("after_abort");
    check("fifo_consumed", 32'(fifo_q.size()), 32'd0);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_module.md
UART_TX_MODULE -- requirements
Module: uart_tx_module

Interface
REQ-001 SHALL have parameter NB_DATA, default 8: data bits per frame.
REQ-002 SHALL have parameter SB_TICK, default 16: stop-bit length in oversample ticks (16 = 1 stop bit).
REQ-003 SHALL have parameter BAUD_DIV, default 163: clock cycles per oversample tick (50 MHz / 19200 baud / 16).
REQ-004 SHALL have port i_clk  input  1  clock; all logic on the rising edge.
REQ-005 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_fifo_empty  input  1  upstream TX FIFO empty flag.
REQ-007 SHALL have port i_fifo_data  input  NB_DATA  FIFO head word, combinationally valid while the FIFO is not empty.
REQ-008 SHALL have port o_fifo_read  output  1  one-cycle pop strobe to the FIFO.
REQ-009 SHALL have port o_tx  output  1  serial line; idle high.
REQ-010 SHALL have port o_busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-011 SHALL generate an oversample tick: counter 0..BAUD_DIV-1, tick high for one cycle when the count equals BAUD_DIV-1.
REQ-012 SHALL clear the tick counter to 0 in the cycle o_fifo_read is high, so every bit lasts exactly 16*BAUD_DIV cycles.
REQ-013 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-014 In IDLE with i_fifo_empty=0, SHALL drive o_fifo_read=1 for exactly that cycle, capture i_fifo_data into the shift register, and enter START.
REQ-015 In IDLE with i_fifo_empty=1, SHALL keep o_fifo_read=0 and remain in IDLE.
REQ-016 SHALL never assert o_fifo_read outside IDLE; exactly one pop per frame.
REQ-017 In START, SHALL hold o_tx=0 for 16 ticks, then enter DATA with bit index 0.
REQ-018 In DATA, SHALL drive the shift register LSB for 16 ticks per bit, shift right after each bit, and leave after bit NB_DATA-1 for PARITY (if enabled) or STOP.
REQ-019 In STOP, SHALL hold o_tx=1 for SB_TICK ticks, then return to IDLE.
REQ-020 SHALL register o_tx, aligned with the state currently held, with no combinational glitches.
REQ-021 Back-to-back frames: SHALL spend exactly one IDLE cycle between the end of STOP and the next o_fifo_read.
REQ-022 Tick counter (0..15 within a bit) and bit index SHALL use minimal widths; the bit index wraps only through the state change, never modulo.

Reset
REQ-023 On i_reset=1, SHALL enter IDLE next edge: o_tx=1, o_fifo_read=0, o_busy=0, tick and bit counters 0, shift register 0.
REQ-024 Reset mid-frame SHALL abort the frame; the aborted byte is not re-read; transmission resumes from the next FIFO word after release.

Configuration
REQ-025 With UART_TX_PARITY_EN defined, SHALL insert one PARITY bit (16 ticks, even parity over the data bits) between DATA and STOP.
REQ-026 Without UART_TX_PARITY_EN, SHALL omit the PARITY state logic entirely; DATA goes directly to STOP.

Structure
REQ-027 Package uart_pkg SHALL hold the state-encoding constants and the default NB_DATA/SB_TICK/BAUD_DIV values.
REQ-028 The tick generator SHALL be the sub-module baud_rate_gen (ports i_clk, i_reset, i_clear, o_tick).

Verification (BAUD_DIV=4, bit = 64 cycles)
REQ-029 Reset asserted 3 cycles -> o_tx=1, o_fifo_read=0, o_busy=0 on the first edge after assertion.
REQ-030 FIFO holds 0xA5 -> one read pulse; o_tx = 0 for 64 cycles, then 1,0,1,0,0,1,0,1 at 64 cycles each, then 1 for 64; o_busy high for 640 cycles.
REQ-031 i_fifo_empty held 1 for 2000 cycles -> no read pulse; o_tx constantly 1.
REQ-032 FIFO holds 0x00 then 0xFF -> two read pulses exactly 641 cycles apart; the second frame is bit-exact.
REQ-033 Reset during DATA bit 3 of 0x5A -> o_tx=1 next cycle; after release with FIFO non-empty, the next word is read; 0x5A is never retransmitted.
REQ-034 UART_TX_PARITY_EN defined: 0xA5 -> parity bit 0; 0x07 -> parity bit 1; frame 704 cycles.
